// File: rtl/cnn_sched_pkg.sv
// Shared types and default sizing for the CNN layer tile scheduler.
package cnn_sched_pkg;
  localparam int NUM_PE_DEF = 16;
  localparam int ADDR_W_DEF = 22;
  localparam int FG_W_DEF   = 7;

  typedef enum logic [2:0] {IDLE, CFG, ISSUE, WAIT, NEXT, DONE} sched_state_e;

  typedef struct packed {
    logic [8:0]  ifm_size;
    logic [1:0]  kernel_size;
    logic [10:0] num_filter;
    logic        pool;
    logic [1:0]  stride;
    logic        up;
  } layer_cfg_t;
endpackage

// File: rtl/layer_geom_calc.sv
// Derives per-layer tiling geometry from the latched config; results are registered on load.
module layer_geom_calc
  import cnn_sched_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FG_W   = FG_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      load,
  input  logic [8:0]                ifm_size,
  input  logic [1:0]                kernel_size,
  input  logic [10:0]               num_filter,
  input  logic                      maxpool_mode,
  input  logic [1:0]                maxpool_stride,
  input  logic                      upsample_mode,
  output logic                      degenerate,
  output logic [8:0]                last_row,
  output logic [1:0]                row_step,
  output logic [ADDR_W-1:0]         rd_step,
  output logic [ADDR_W-1:0]         wr_step,
  output logic [ADDR_W-1:0]         grp_stride,
  output logic [ADDR_W-1:0]         ifm_plane,
  output logic [ADDR_W-1:0]         ofm_plane,
  output logic [FG_W-1:0]           nfg,
  output logic [$clog2(NUM_PE):0]   last_cnt
);
  localparam int PE_LG = $clog2(NUM_PE);
  localparam int CNT_W = PE_LG + 1;

  logic              pool2;
  logic [8:0]        conv_d, last_row_d, last_row_q;
  logic [9:0]        ofm_d;
  logic [11:0]       nf_rnd;
  logic [1:0]        row_step_d, row_step_q;
  logic [ADDR_W-1:0] rd_step_d, rd_step_q, wr_step_d, wr_step_q, grp_stride_d, grp_stride_q;
  logic [ADDR_W-1:0] ifm_plane_d, ifm_plane_q, ofm_plane_d, ofm_plane_q;
  logic [FG_W-1:0]   nfg_d, nfg_q;
  logic [CNT_W-1:0]  last_cnt_d, last_cnt_q;

  always_comb begin
    pool2  = maxpool_mode && (maxpool_stride == 2'd2);
    conv_d = ifm_size - 9'(kernel_size) + 9'd1;
    if (pool2)              ofm_d = {2'b0, conv_d[8:1]};
    else if (upsample_mode) ofm_d = {conv_d, 1'b0};
    else                    ofm_d = {1'b0, conv_d};
    // Pool stride 2 consumes conv rows in pairs; an odd trailing row is dropped.
    last_row_d   = pool2 ? ({conv_d[8:1], 1'b0} - 9'd2) : (conv_d - 9'd1);
    row_step_d   = pool2 ? 2'd2 : 2'd1;
    rd_step_d    = pool2 ? ADDR_W'({ifm_size, 1'b0}) : ADDR_W'(ifm_size);
    wr_step_d    = (upsample_mode && !pool2) ? ADDR_W'({ofm_d, 1'b0}) : ADDR_W'(ofm_d);
    ifm_plane_d  = ADDR_W'(ifm_size) * ADDR_W'(ifm_size);
    ofm_plane_d  = ADDR_W'(ofm_d) * ADDR_W'(ofm_d);
    grp_stride_d = ofm_plane_d << PE_LG;
    nf_rnd       = {1'b0, num_filter} + 12'(NUM_PE - 1);
    nfg_d        = FG_W'(nf_rnd >> PE_LG);
    last_cnt_d   = (num_filter[PE_LG-1:0] == '0) ? CNT_W'(NUM_PE) : CNT_W'(num_filter[PE_LG-1:0]);
    degenerate   = (num_filter == 11'd0) || (kernel_size == 2'd0) ||
                   (ifm_size < 9'(kernel_size)) || (ofm_d == 10'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_row_q   <= '0;
      row_step_q   <= '0;
      rd_step_q    <= '0;
      wr_step_q    <= '0;
      grp_stride_q <= '0;
      ifm_plane_q  <= '0;
      ofm_plane_q  <= '0;
      nfg_q        <= '0;
      last_cnt_q   <= '0;
    end else if (load) begin
      last_row_q   <= last_row_d;
      row_step_q   <= row_step_d;
      rd_step_q    <= rd_step_d;
      wr_step_q    <= wr_step_d;
      grp_stride_q <= grp_stride_d;
      ifm_plane_q  <= ifm_plane_d;
      ofm_plane_q  <= ofm_plane_d;
      nfg_q        <= nfg_d;
      last_cnt_q   <= last_cnt_d;
    end
  end

  assign last_row   = last_row_q;
  assign row_step   = row_step_q;
  assign rd_step    = rd_step_q;
  assign wr_step    = wr_step_q;
  assign grp_stride = grp_stride_q;
  assign ifm_plane  = ifm_plane_q;
  assign ofm_plane  = ofm_plane_q;
  assign nfg        = nfg_q;
  assign last_cnt   = last_cnt_q;
endmodule

// File: rtl/layer_tile_scheduler.sv
// Walks filter groups x output rows of one CNN layer, issuing one tile command per step.
module layer_tile_scheduler
  import cnn_sched_pkg::*;
#(
  parameter int NUM_PE = NUM_PE_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int FG_W   = FG_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_layer,
  input  logic [8:0]              ifm_size,
  input  logic [10:0]             ifm_channel,
  input  logic [1:0]              kernel_size,
  input  logic [10:0]             num_filter,
  input  logic                    maxpool_mode,
  input  logic [1:0]              maxpool_stride,
  input  logic                    upsample_mode,
  input  logic [ADDR_W-1:0]       start_read_addr,
  input  logic [ADDR_W-1:0]       start_write_addr,
  output logic                    tile_valid,
  input  logic                    tile_ready,
  input  logic                    tile_done,
  output logic [8:0]              tile_row,
  output logic [FG_W-1:0]         tile_fgrp,
  output logic [$clog2(NUM_PE):0] tile_num_filt,
  output logic [ADDR_W-1:0]       tile_rd_addr,
  output logic [ADDR_W-1:0]       tile_wr_addr,
  output logic [ADDR_W-1:0]       tile_ifm_plane,
  output logic [ADDR_W-1:0]       tile_ofm_plane,
  output logic                    busy,
  output logic                    done_layer,
  output logic                    err_proto
);
  localparam int CNT_W = $clog2(NUM_PE) + 1;

  sched_state_e      state_q, state_d;
  layer_cfg_t        cfg_q, cfg_d;
  logic [8:0]        row_q, row_d;
  logic [FG_W-1:0]   fgrp_q, fgrp_d;
  logic [ADDR_W-1:0] rd_base_q, rd_base_d, rd_q, rd_d, wr_q, wr_d, grp_base_q, grp_base_d;
  logic              err_q, err_d;

  logic              g_degen;
  logic [8:0]        g_last_row;
  logic [1:0]        g_row_step;
  logic [ADDR_W-1:0] g_rd_step, g_wr_step, g_grp_stride;
  logic [FG_W-1:0]   g_nfg;
  logic [CNT_W-1:0]  g_last_cnt;
  logic              last_row, last_grp, unused_chan;

  // Channel depth is consumed by the PE engine directly; tiling does not depend on it.
  assign unused_chan = ^ifm_channel;

  layer_geom_calc #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .FG_W(FG_W)) u_geom (
    .clk(clk), .rst(rst), .load(state_q == CFG),
    .ifm_size(cfg_q.ifm_size), .kernel_size(cfg_q.kernel_size), .num_filter(cfg_q.num_filter),
    .maxpool_mode(cfg_q.pool), .maxpool_stride(cfg_q.stride), .upsample_mode(cfg_q.up),
    .degenerate(g_degen), .last_row(g_last_row), .row_step(g_row_step),
    .rd_step(g_rd_step), .wr_step(g_wr_step), .grp_stride(g_grp_stride),
    .ifm_plane(tile_ifm_plane), .ofm_plane(tile_ofm_plane),
    .nfg(g_nfg), .last_cnt(g_last_cnt)
  );

  assign last_row = (row_q == g_last_row);
  assign last_grp = (fgrp_q == g_nfg - FG_W'(1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_layer) state_d = CFG;
      CFG:     state_d = g_degen ? DONE : ISSUE;
      ISSUE:   if (tile_ready) state_d = WAIT;
      WAIT:    if (tile_done) state_d = NEXT;
      NEXT:    state_d = (last_row && last_grp) ? DONE : ISSUE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    tile_valid    = (state_q == ISSUE);
    busy          = (state_q != IDLE);
    done_layer    = (state_q == DONE);
    tile_num_filt = '0;
    if (state_q != IDLE) tile_num_filt = last_grp ? g_last_cnt : CNT_W'(NUM_PE);
  end

  // Addresses advance by accumulation; a group wrap rebases on the next OFM channel block.
  always_comb begin
    cfg_d      = cfg_q;
    rd_base_d  = rd_base_q;
    row_d      = row_q;
    fgrp_d     = fgrp_q;
    rd_d       = rd_q;
    wr_d       = wr_q;
    grp_base_d = grp_base_q;
    err_d      = err_q | (tile_done && (state_q != WAIT));
    if (state_q == IDLE && start_layer) begin
      cfg_d      = '{ifm_size: ifm_size, kernel_size: kernel_size, num_filter: num_filter,
                     pool: maxpool_mode, stride: maxpool_stride, up: upsample_mode};
      rd_base_d  = start_read_addr;
      rd_d       = start_read_addr;
      wr_d       = start_write_addr;
      grp_base_d = start_write_addr;
      row_d      = '0;
      fgrp_d     = '0;
    end else if (state_q == NEXT && !(last_row && last_grp)) begin
      if (last_row) begin
        row_d      = '0;
        fgrp_d     = fgrp_q + FG_W'(1);
        rd_d       = rd_base_q;
        grp_base_d = grp_base_q + g_grp_stride;
        wr_d       = grp_base_d;
      end else begin
        row_d = row_q + 9'(g_row_step);
        rd_d  = rd_q + g_rd_step;
        wr_d  = wr_q + g_wr_step;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q      <= '0;
      rd_base_q  <= '0;
      row_q      <= '0;
      fgrp_q     <= '0;
      rd_q       <= '0;
      wr_q       <= '0;
      grp_base_q <= '0;
      err_q      <= 1'b0;
    end else begin
      cfg_q      <= cfg_d;
      rd_base_q  <= rd_base_d;
      row_q      <= row_d;
      fgrp_q     <= fgrp_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
      grp_base_q <= grp_base_d;
      err_q      <= err_d;
    end
  end

  assign tile_row     = row_q;
  assign tile_fgrp    = fgrp_q;
  assign tile_rd_addr = rd_q;
  assign tile_wr_addr = wr_q;
  assign err_proto    = err_q;
endmodule

// File: tb/tb_layer_tile_scheduler.sv
// Scoreboard bench: expected tiles are queued at stimulus time, a monitor pops on each acceptance.
module tb_layer_tile_scheduler;
  localparam int NUM_PE = 16;
  localparam int ADDR_W = 22;
  localparam int FG_W   = 7;

  typedef struct { int row; int fgrp; int nf; int rd; int wr; int ip; int op; } tile_t;

  logic clk = 1'b0;
  logic rst = 1'b1, start_layer = 1'b0;
  logic [8:0] ifm_size = '0;
  logic [10:0] ifm_channel = 11'd3, num_filter = '0;
  logic [1:0] kernel_size = '0, maxpool_stride = '0;
  logic maxpool_mode = 1'b0, upsample_mode = 1'b0;
  logic [ADDR_W-1:0] start_read_addr = '0, start_write_addr = '0;
  logic tile_valid, tile_ready, tile_done, busy, done_layer, err_proto;
  logic [8:0] tile_row;
  logic [FG_W-1:0] tile_fgrp;
  logic [$clog2(NUM_PE):0] tile_num_filt;
  logic [ADDR_W-1:0] tile_rd_addr, tile_wr_addr, tile_ifm_plane, tile_ofm_plane;

  logic eng_ready = 1'b0, eng_done = 1'b0, man_ready = 1'b0, man_done = 1'b0;
  bit   eng_en = 1'b0;
  int   eng_dly = 0;
  int   nvec = 0, nerr = 0, cyc = 0, done_cnt = 0, done_cyc = 0, last_tdone_cyc = 0, st_cyc = 0;
  tile_t exp_q[$], acc_log[$];
  int    exp_done_q[$];
  tile_t cur, e;

  assign tile_ready = eng_ready | man_ready;
  assign tile_done  = eng_done | man_done;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  layer_tile_scheduler #(.NUM_PE(NUM_PE), .ADDR_W(ADDR_W), .FG_W(FG_W)) dut (
    .clk(clk), .rst(rst), .start_layer(start_layer), .ifm_size(ifm_size), .ifm_channel(ifm_channel),
    .kernel_size(kernel_size), .num_filter(num_filter), .maxpool_mode(maxpool_mode),
    .maxpool_stride(maxpool_stride), .upsample_mode(upsample_mode),
    .start_read_addr(start_read_addr), .start_write_addr(start_write_addr),
    .tile_valid(tile_valid), .tile_ready(tile_ready), .tile_done(tile_done),
    .tile_row(tile_row), .tile_fgrp(tile_fgrp), .tile_num_filt(tile_num_filt),
    .tile_rd_addr(tile_rd_addr), .tile_wr_addr(tile_wr_addr),
    .tile_ifm_plane(tile_ifm_plane), .tile_ofm_plane(tile_ofm_plane),
    .busy(busy), .done_layer(done_layer), .err_proto(err_proto)
  );

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference tile list computed with direct multiplies from the layer parameters.
  task automatic push_layer(input int ifm, k, nf, pool, stride, up, rdb, wrb, input bit with_done);
    int conv, ofm, ntl, step, nfg, wstep;
    tile_t t;
    conv = ifm - k + 1;
    if (pool != 0 && stride == 2) begin ofm = conv / 2; ntl = conv / 2; step = 2; end
    else begin ofm = (up != 0) ? conv * 2 : conv; ntl = conv; step = 1; end
    wstep = (up != 0 && !(pool != 0 && stride == 2)) ? 2 * ofm : ofm;
    nfg = (nf + NUM_PE - 1) / NUM_PE;
    for (int g = 0; g < nfg; g++)
      for (int i = 0; i < ntl; i++) begin
        t.row = i * step; t.fgrp = g;
        t.nf = (nf - g * NUM_PE < NUM_PE) ? nf - g * NUM_PE : NUM_PE;
        t.rd = rdb + t.row * ifm;
        t.wr = wrb + g * NUM_PE * ofm * ofm + i * wstep;
        t.ip = ifm * ifm; t.op = ofm * ofm;
        exp_q.push_back(t);
      end
    if (with_done) exp_done_q.push_back(1);
  endtask

  task automatic start(input int ifm, k, nf, pool, stride, up, rdb, wrb);
    ifm_size = 9'(ifm); kernel_size = 2'(k); num_filter = 11'(nf);
    maxpool_mode = 1'(pool); maxpool_stride = 2'(stride); upsample_mode = 1'(up);
    start_read_addr = ADDR_W'(rdb); start_write_addr = ADDR_W'(wrb);
    start_layer = 1'b1; st_cyc = cyc;
    @(posedge clk); #1;
    start_layer = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int n0);
    for (int i = 0; i < 30000 && done_cnt == n0; i++) @(posedge clk);
    #1;
    check(nm, done_cnt, n0 + 1);
  endtask

  task automatic wait_valid(input string nm);
    for (int i = 0; i < 50 && tile_valid !== 1'b1; i++) begin @(posedge clk); #1; end
    check(nm, int'(tile_valid), 1);
  endtask

  // Engine model: accept immediately, report completion eng_dly cycles later.
  initial forever begin
    @(posedge clk); #1;
    eng_ready = 1'b0; eng_done = 1'b0;
    if (eng_en && tile_valid === 1'b1 && !rst) begin
      eng_ready = 1'b1;
      @(posedge clk); #1;
      eng_ready = 1'b0;
      repeat (eng_dly) begin @(posedge clk); #1; end
      if (eng_en) eng_done = 1'b1;
    end
  end

  initial forever begin
    @(negedge clk);
    if (tile_valid === 1'b1 && tile_ready === 1'b1 && !rst) begin
      cur.row = int'(tile_row); cur.fgrp = int'(tile_fgrp); cur.nf = int'(tile_num_filt);
      cur.rd = int'(tile_rd_addr); cur.wr = int'(tile_wr_addr);
      cur.ip = int'(tile_ifm_plane); cur.op = int'(tile_ofm_plane);
      acc_log.push_back(cur);
      if (exp_q.size() == 0) check("tile_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("tile_row", cur.row, e.row);
        check("tile_fgrp", cur.fgrp, e.fgrp);
        check("tile_num_filt", cur.nf, e.nf);
        check("tile_rd_addr", cur.rd, e.rd);
        check("tile_wr_addr", cur.wr, e.wr);
        check("tile_ifm_plane", cur.ip, e.ip);
        check("tile_ofm_plane", cur.op, e.op);
      end
    end
    if (tile_done === 1'b1) last_tdone_cyc = cyc;
    if (done_layer === 1'b1) begin
      done_cnt++; done_cyc = cyc;
      if (exp_done_q.size() == 0) check("done_unexpected", 1, 0);
      else void'(exp_done_q.pop_front());
      check("tiles_left_at_done", exp_q.size(), 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, m;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("rst_valid", int'(tile_valid), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done_layer), 0);
    check("rst_err", int'(err_proto), 0);
    check("rst_row", int'(tile_row), 0);
    check("rst_num_filt", int'(tile_num_filt), 0);
    check("rst_wr_addr", int'(tile_wr_addr), 0);
    check("rst_ofm_plane", int'(tile_ofm_plane), 0);

    // 222x222 k3 pool s2: 110 tiles on even rows
    eng_dly = 0; eng_en = 1'b1; acc_log.delete(); n0 = done_cnt;
    push_layer(222, 3, 16, 1, 2, 0, 100, 0, 1'b1);
    start(222, 3, 16, 1, 2, 0, 100, 0);
    wait_done("t1_done_timeout", n0);
    check("t1_tiles", acc_log.size(), 110);
    if (acc_log.size() == 110) begin
      check("t1_row1", acc_log[1].row, 2);
      check("t1_last_row", acc_log[109].row, 218);
      check("t1_last_wr", acc_log[109].wr, 11990);
    end
    check("t1_done_lat", done_cyc - last_tdone_cyc, 2);

    // 13x13 k1 nf255: 16 groups, short last group
    acc_log.delete(); n0 = done_cnt;
    push_layer(13, 1, 255, 0, 1, 0, 40, 1000, 1'b1);
    start(13, 1, 255, 0, 1, 0, 40, 1000);
    wait_done("t2_done_timeout", n0);
    check("t2_tiles", acc_log.size(), 208);
    if (acc_log.size() == 208) begin
      check("t2_g1r0_fgrp", acc_log[13].fgrp, 1);
      check("t2_g1r0_wr", acc_log[13].wr, 1000 + 16 * 169);
      check("t2_g15_fgrp", acc_log[207].fgrp, 15);
      check("t2_g15_nf", acc_log[207].nf, 15);
      check("t2_ifm_plane", acc_log[0].ip, 169);
    end
    check("t2_done_lat", done_cyc - last_tdone_cyc, 2);

    // upsample: 26x26 OFM, two OFM rows per tile
    acc_log.delete(); n0 = done_cnt;
    push_layer(13, 1, 128, 0, 1, 1, 0, 0, 1'b1);
    start(13, 1, 128, 0, 1, 1, 0, 0);
    wait_done("t3_done_timeout", n0);
    check("t3_tiles", acc_log.size(), 104);
    if (acc_log.size() == 104) begin
      check("t3_ofm_plane", acc_log[0].op, 676);
      check("t3_wr_step", acc_log[1].wr - acc_log[0].wr, 52);
      check("t3_g1_wr", acc_log[13].wr, 16 * 676);
    end

    // backpressure: ready held low 5 cycles
    eng_en = 1'b0; acc_log.delete(); n0 = done_cnt;
    push_layer(13, 1, 16, 0, 1, 0, 500, 2000, 1'b1);
    start(13, 1, 16, 0, 1, 0, 500, 2000);
    wait_valid("t4_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      check("t4_hold_valid", int'(tile_valid), 1);
      check("t4_hold_row", int'(tile_row), 0);
      check("t4_hold_rd", int'(tile_rd_addr), 500);
      check("t4_hold_wr", int'(tile_wr_addr), 2000);
      check("t4_hold_nf", int'(tile_num_filt), 16);
      @(posedge clk); #1;
    end
    man_ready = 1'b1;
    @(posedge clk); #1;
    man_ready = 1'b0;
    check("t4_accepted", int'(tile_valid), 0);
    check("t4_accept_count", acc_log.size(), 1);
    man_done = 1'b1; m = cyc;
    @(posedge clk); #1;
    man_done = 1'b0;
    check("t4_next_gap", int'(tile_valid), 0);
    @(posedge clk); #1;
    check("t4_reissue", int'(tile_valid), 1);
    check("t4_reissue_lat", cyc - m, 2);
    check("t4_row_adv", int'(tile_row), 1);
    check("t4_rd_adv", int'(tile_rd_addr), 513);
    check("t4_wr_adv", int'(tile_wr_addr), 2013);
    eng_en = 1'b1;
    wait_done("t4_done_timeout", n0);
    check("t4_tiles", acc_log.size(), 13);

    // degenerate num_filter=0, plus ignored start while busy, ready held high
    eng_en = 1'b0; man_ready = 1'b1; acc_log.delete(); n0 = done_cnt;
    push_layer(13, 3, 0, 0, 1, 0, 0, 0, 1'b1);
    start(13, 3, 0, 0, 1, 0, 0, 0);
    ifm_size = 9'd13; kernel_size = 2'd1; num_filter = 11'd16; start_layer = 1'b1;
    @(posedge clk); #1;
    start_layer = 1'b0;
    check("t5_done_pulse", int'(done_layer), 1);
    repeat (6) begin @(posedge clk); #1; end
    man_ready = 1'b0;
    check("t5_done_count", done_cnt - n0, 1);
    check("t5_done_lat", done_cyc - st_cyc, 2);
    check("t5_no_tiles", acc_log.size(), 0);
    check("t5_idle", int'(busy), 0);

    // reset mid-layer at tile 40
    eng_dly = 2; eng_en = 1'b1; acc_log.delete(); n0 = done_cnt;
    push_layer(13, 1, 128, 0, 1, 0, 0, 0, 1'b0);
    start(13, 1, 128, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2000 && acc_log.size() < 40; i++) begin @(posedge clk); #2; end
    check("t6_reach40", acc_log.size(), 40);
    eng_en = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("t6_rst_busy", int'(busy), 0);
    check("t6_rst_valid", int'(tile_valid), 0);
    exp_q.delete();
    repeat (6) begin @(posedge clk); #1; end
    check("t6_no_done", done_cnt, n0);
    check("t6_no_extra", acc_log.size(), 40);
    check("t6_err_clear", int'(err_proto), 0);

    // fresh layer; stray tile_done while ISSUE
    eng_dly = 0; acc_log.delete(); n0 = done_cnt;
    push_layer(4, 3, 5, 0, 1, 0, 0, 64, 1'b1);
    start(4, 3, 5, 0, 1, 0, 0, 64);
    wait_valid("t7_valid_timeout");
    check("t7_row_restart", int'(tile_row), 0);
    man_done = 1'b1;
    @(posedge clk); #1;
    man_done = 1'b0;
    check("t7_err_set", int'(err_proto), 1);
    check("t7_still_issue", int'(tile_valid), 1);
    eng_en = 1'b1;
    wait_done("t7_done_timeout", n0);
    check("t7_tiles", acc_log.size(), 2);
    check("t7_err_sticky", int'(err_proto), 1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
